mcp_control_fsm: RTL

//  Multicycle MIPS main controller: Moore FSM that sequences data_path per instruction.

---
 rtl/mcp_pkg.sv | 64 ++++++
 rtl/mcp_out_decode.sv | 80 ++++++++
 rtl/mcp_control_fsm.sv | 100 ++++++++++
 3 files changed

// File: rtl/mcp_pkg.sv
// Shared types for the multicycle MIPS main controller: state encoding,
// opcode constants, control-field enums and the packed control word.
// Optional feature: MCP_ADDI_EN enables the ADDI execute/write-back states.
package mcp_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_JEX     = 4'd9,
        S_ADDIEX  = 4'd10,
        S_ADDIWB  = 4'd11
    } state_e;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    // Next-PC source select.
    typedef enum logic [1:0] {
        PC_ALU_RES = 2'b00,
        PC_ALU_OUT = 2'b01,
        PC_JUMP    = 2'b10
    } pcsrc_e;

    // ALU B operand select.
    typedef enum logic [1:0] {
        SRCB_B      = 2'b00,
        SRCB_FOUR   = 2'b01,
        SRCB_IMM    = 2'b10,
        SRCB_IMM_SH = 2'b11
    } srcb_e;

    // ALU operation override; 2'b11 is reserved and never produced.
    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_FUNCT = 2'b10
    } alu_alt_e;

    typedef struct packed {
        logic     pc_we;       // unconditional PC write
        pcsrc_e   pc_src;
        logic     iord;        // 0: PC addresses memory, 1: alu_out_reg
        logic     instr_we;
        logic     mem_we;
        logic     reg_dst;     // 0: rt, 1: rd
        logic     mem_to_reg;  // 0: alu_out_reg, 1: data_reg
        logic     reg_we;
        logic     srca;        // 0: PC, 1: A register
        srcb_e    srcb;
        alu_alt_e alu;
    } ctrl_word_t;

endpackage

// File: rtl/mcp_out_decode.sv
// Moore output decode: maps the controller state to the data_path control word.
// MCP_ADDI_EN: when undefined the ADDI states decode like any unused encoding (all 0).
module mcp_out_decode
    import mcp_pkg::*;
(
    input  state_e     i_state,
    output ctrl_word_t o_ctrl
);

    // Control word for the current state; fields not set stay 0.
    always_comb begin
        // NOTE: defaulting the whole word first keeps every path assigned, so no latch is inferred.
        o_ctrl = '0;
        unique case (i_state)
            S_FETCH: begin
                o_ctrl.instr_we = 1'b1;
                o_ctrl.pc_we    = 1'b1;
                o_ctrl.srca     = 1'b0;
                o_ctrl.srcb     = SRCB_FOUR;
                o_ctrl.alu      = ALU_ADD;
                o_ctrl.pc_src   = PC_ALU_RES;
            end
            S_DECODE: begin
                // Precompute the branch target into alu_out_reg.
                o_ctrl.srcb = SRCB_IMM_SH;
                o_ctrl.alu  = ALU_ADD;
            end
            S_MEMADR: begin
                o_ctrl.srca = 1'b1;
                o_ctrl.srcb = SRCB_IMM;
                o_ctrl.alu  = ALU_ADD;
            end
            S_MEMRD: begin
                o_ctrl.iord = 1'b1;
            end
            S_MEMWB: begin
                o_ctrl.reg_we     = 1'b1;
                o_ctrl.reg_dst    = 1'b0;
                o_ctrl.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                o_ctrl.iord   = 1'b1;
                o_ctrl.mem_we = 1'b1;
            end
            S_RTYPEEX: begin
                o_ctrl.srca = 1'b1;
                o_ctrl.srcb = SRCB_B;
                o_ctrl.alu  = ALU_FUNCT;
            end
            S_RTYPEWB: begin
                o_ctrl.reg_we  = 1'b1;
                o_ctrl.reg_dst = 1'b1;
            end
            S_BEQEX: begin
                // PC write here is qualified by zero in the FSM, not in this table.
                o_ctrl.srca   = 1'b1;
                o_ctrl.srcb   = SRCB_B;
                o_ctrl.alu    = ALU_SUB;
                o_ctrl.pc_src = PC_ALU_OUT;
            end
            S_JEX: begin
                o_ctrl.pc_src = PC_JUMP;
                o_ctrl.pc_we  = 1'b1;
            end
`ifdef MCP_ADDI_EN
            S_ADDIEX: begin
                o_ctrl.srca = 1'b1;
                o_ctrl.srcb = SRCB_IMM;
                o_ctrl.alu  = ALU_ADD;
            end
            S_ADDIWB: begin
                o_ctrl.reg_we  = 1'b1;
                o_ctrl.reg_dst = 1'b0;
            end
`endif
            default: o_ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mcp_control_fsm.sv
// Multicycle MIPS main controller: Moore FSM sequencing data_path per instruction.
// Holds the state register, next-state dispatch, BEQ qualification of pc_we_o and
// the illegal-opcode flag. MCP_ADDI_EN adds ADDI support; otherwise ADDI is illegal.
module mcp_control_fsm
    import mcp_pkg::*;
#(
    parameter int STATE_W        = 4,
    parameter bit ILLEGAL_STICKY = 1'b1
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [5:0]         opcode_i6,
    input  logic               zero_i,
    output logic               pc_we_o,
    output logic [1:0]         pc_branch_o2,
    output logic               instr_or_data_o,
    output logic               instr_we_o,
    output logic               mem_we_o,
    output logic               reg_dst_rtrd_o,
    output logic               mem_to_reg_o,
    output logic               enable_wrf_o,
    output logic               a_alu_input_o,
    output logic [1:0]         b_alu_input_o2,
    output logic [1:0]         alu_alt_ctrl_o2,
    output logic               illegal_op_o,
    output logic [STATE_W-1:0] state_o
);

    state_e     r_state;
    state_e     w_next_state;
    logic       w_illegal_dec;
    logic       r_illegal;
    ctrl_word_t w_ctrl;

    // State register; reset aborts any instruction and restarts at FETCH.
    always_ff @(posedge clk_i or posedge reset_i) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (reset_i) r_state <= S_FETCH;
        else         r_state <= w_next_state;
    end

    // Next-state logic and opcode dispatch out of DECODE.
    always_comb begin
        w_next_state  = S_FETCH;
        w_illegal_dec = 1'b0;
        unique case (r_state)
            S_FETCH:  w_next_state = S_DECODE;
            S_DECODE: begin
                unique case (opcode_i6)
                    OP_LW, OP_SW: w_next_state = S_MEMADR;
                    OP_R:         w_next_state = S_RTYPEEX;
                    OP_BEQ:       w_next_state = S_BEQEX;
                    OP_J:         w_next_state = S_JEX;
`ifdef MCP_ADDI_EN
                    OP_ADDI:      w_next_state = S_ADDIEX;
`endif
                    default: begin
                        w_next_state  = S_FETCH;
                        w_illegal_dec = 1'b1;
                    end
                endcase
            end
            S_MEMADR:  w_next_state = (opcode_i6 == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   w_next_state = S_MEMWB;
            S_RTYPEEX: w_next_state = S_RTYPEWB;
`ifdef MCP_ADDI_EN
            S_ADDIEX:  w_next_state = S_ADDIWB;
`endif
            default:   w_next_state = S_FETCH;
        endcase
    end

    // Illegal-opcode flag: registered, so it rises the cycle after DECODE.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i)             r_illegal <= 1'b0;
        else if (ILLEGAL_STICKY) r_illegal <= r_illegal | w_illegal_dec;
        else                     r_illegal <= w_illegal_dec;
    end

    mcp_out_decode u_out_decode (
        .i_state (r_state),
        .o_ctrl  (w_ctrl)
    );

    // BEQ writes the PC only when the ALU reports equality this cycle.
    assign pc_we_o         = w_ctrl.pc_we | ((r_state == S_BEQEX) & zero_i);
    assign pc_branch_o2    = w_ctrl.pc_src;
    assign instr_or_data_o = w_ctrl.iord;
    assign instr_we_o      = w_ctrl.instr_we;
    assign mem_we_o        = w_ctrl.mem_we;
    assign reg_dst_rtrd_o  = w_ctrl.reg_dst;
    assign mem_to_reg_o    = w_ctrl.mem_to_reg;
    assign enable_wrf_o    = w_ctrl.reg_we;
    assign a_alu_input_o   = w_ctrl.srca;
    assign b_alu_input_o2  = w_ctrl.srcb;
    assign alu_alt_ctrl_o2 = w_ctrl.alu;
    assign illegal_op_o    = r_illegal;
    assign state_o         = STATE_W'(r_state);

endmodule
